// File: rtl/glb_access_arbiter_pkg.sv
// Shared definitions for the GLB access arbiter: sizing helper,
// requester indices and controller state encodings.
package glb_access_arbiter_pkg;

  // Number of bits needed to hold the given value (0 -> 0, 2 -> 2, 8191 -> 13).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

  localparam int NUM_REQ     = 4;
  localparam int REQ_IFMAP   = 0;
  localparam int REQ_WGHT    = 1;
  localparam int REQ_PSUM_RD = 2;
  localparam int REQ_PSUM_WR = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/glb_access_arbiter_rr_arbiter4.sv
// Four-way round-robin arbiter: one-hot grant, pointer advances past the
// winner so every persistent requester is served within four cycles.
module rr_arbiter4
  import glb_access_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] gnt_idx;
  logic       gnt_any;

  // Scan from the pointer upward; the nearest active requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_en && i_req[ptr_q + 2'(i)]) begin
        gnt_any = 1'b1;
        gnt_idx = ptr_q + 2'(i);
      end
    end
    o_gnt = gnt_any ? 4'(4'b0001 << gnt_idx) : 4'b0000;
    ptr_d = gnt_any ? gnt_idx + 2'd1 : ptr_q;
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/glb_access_arbiter.sv
// Global-buffer access arbiter: shares the single GLB port among the ifmap,
// weight and psum requesters, tags read responses with the requester id and
// lets the controller drain traffic between passes.
module glb_access_arbiter
  import glb_access_arbiter_pkg::*;
#(
  parameter int DATA_BITWIDTH = 32,
  parameter int BANK_NUM      = 3,
  parameter int BANK_DEPTH    = 8192,
  parameter int RD_LAT        = 1,
  parameter int BANK_SEL_W    = clogb2(BANK_NUM - 1),
  parameter int ADDR_W        = clogb2(BANK_DEPTH - 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [3*BANK_SEL_W-1:0]   i_bank_map,
  input  logic [3:0]                i_req_valid,
  output logic [3:0]                o_req_ready,
  input  logic [4*ADDR_W-1:0]       i_req_addr,
  input  logic [DATA_BITWIDTH-1:0]  i_wr_data,
  output logic [BANK_SEL_W-1:0]     o_glb_bank_sel,
  output logic                      o_glb_re,
  output logic                      o_glb_we,
  output logic [ADDR_W-1:0]         o_glb_ra,
  output logic [ADDR_W-1:0]         o_glb_wa,
  output logic [DATA_BITWIDTH-1:0]  o_glb_wd,
  input  logic [DATA_BITWIDTH-1:0]  i_glb_rd,
  output logic                      o_rsp_valid,
  output logic [1:0]                o_rsp_id,
  output logic [DATA_BITWIDTH-1:0]  o_rsp_data,
  output logic                      o_idle
);

  state_e                 state_q;
  state_e                 state_d;
  logic                   idle_q;
  logic [3:0]             gnt;
  logic                   arb_en;
  logic [1:0]             rd_id;
  logic [RD_LAT-1:0]      pipe_vld_q;
  logic [RD_LAT-1:0]      pipe_vld_d;
  logic [RD_LAT-1:0][1:0] pipe_id_q;
  logic [RD_LAT-1:0][1:0] pipe_id_d;

  // The map is written MSB-first as {ifmap, psum, wght}, so the ifmap bank
  // sits in the top field and the weight bank in the bottom one.
  logic [BANK_SEL_W-1:0] bank_ifmap;
  logic [BANK_SEL_W-1:0] bank_psum;
  logic [BANK_SEL_W-1:0] bank_wght;

  assign bank_ifmap = i_bank_map[2*BANK_SEL_W +: BANK_SEL_W];
  assign bank_psum  = i_bank_map[1*BANK_SEL_W +: BANK_SEL_W];
  assign bank_wght  = i_bank_map[0*BANK_SEL_W +: BANK_SEL_W];

  // Grants stop as soon as i_en drops, even before the FSM leaves RUN.
  assign arb_en = (state_q == ST_RUN) && i_en;

  rr_arbiter4 u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (arb_en),
    .i_req   (i_req_valid),
    .o_gnt   (gnt)
  );

  assign o_req_ready = gnt;

  // Steer the single GLB port to the granted requester and its bank.
  always_comb begin
    o_glb_re       = |gnt[REQ_PSUM_RD:REQ_IFMAP];
    o_glb_we       = gnt[REQ_PSUM_WR];
    o_glb_bank_sel = '0;
    o_glb_ra       = '0;
    o_glb_wa       = '0;
    o_glb_wd       = '0;
    rd_id          = 2'd0;
    if (gnt[REQ_IFMAP]) begin
      o_glb_bank_sel = bank_ifmap;
      o_glb_ra       = i_req_addr[REQ_IFMAP*ADDR_W +: ADDR_W];
      rd_id          = 2'(REQ_IFMAP);
    end else if (gnt[REQ_WGHT]) begin
      o_glb_bank_sel = bank_wght;
      o_glb_ra       = i_req_addr[REQ_WGHT*ADDR_W +: ADDR_W];
      rd_id          = 2'(REQ_WGHT);
    end else if (gnt[REQ_PSUM_RD]) begin
      o_glb_bank_sel = bank_psum;
      o_glb_ra       = i_req_addr[REQ_PSUM_RD*ADDR_W +: ADDR_W];
      rd_id          = 2'(REQ_PSUM_RD);
    end else if (gnt[REQ_PSUM_WR]) begin
      o_glb_bank_sel = bank_psum;
      o_glb_wa       = i_req_addr[REQ_PSUM_WR*ADDR_W +: ADDR_W];
      o_glb_wd       = i_wr_data;
    end
  end

  // Shift a {valid, id} token per read so it lines up with the GLB data.
  always_comb begin
    pipe_vld_d = RD_LAT'({pipe_vld_q, o_glb_re});
    pipe_id_d  = (2*RD_LAT)'({pipe_id_q, rd_id});
  end

  // Read-tag pipeline; reset discards anything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

  assign o_rsp_valid = pipe_vld_q[RD_LAT-1];
  assign o_rsp_id    = pipe_id_q[RD_LAT-1];
  assign o_rsp_data  = i_glb_rd;

  // Next state: drain leaves for IDLE once the last token shifts out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_en) state_d = ST_RUN;
      ST_RUN:   if (!i_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (i_en) begin
          state_d = ST_RUN;
        end else if (pipe_vld_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Controller FSM with registered idle flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == ST_IDLE);
    end
  end

  assign o_idle = idle_q;

  // Remapping banks with traffic possible would misroute accesses.
  map_stable_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !$stable(i_bank_map) |-> o_idle);

endmodule

// File: tb/tb_glb_access_arbiter.sv
// Bench for glb_access_arbiter: two instances (read latency 1 and 3) share
// the stimulus; each drives its own GLB memory model and response scoreboard.
module tb_glb_access_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int BW    = 2;
  localparam int DEPTH = 8192;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [3*BW-1:0]  bank_map;
  logic [3:0]       req_valid;
  logic [4*AW-1:0]  req_addr;
  logic [DW-1:0]    wr_data;

  logic [3:0]    ready1, ready3;
  logic [BW-1:0] bank1, bank3;
  logic          re1, re3, we1, we3;
  logic [AW-1:0] ra1, ra3, wa1, wa3;
  logic [DW-1:0] wd1, wd3;
  logic [DW-1:0] rd1_q, rd3_s0, rd3_s1, rd3_s2;
  logic          rsp_v1, rsp_v3;
  logic [1:0]    rsp_id1, rsp_id3;
  logic [DW-1:0] rsp_d1, rsp_d3;
  logic          idle1, idle3;

  logic [31:0] mem1    [0:3*DEPTH-1];
  logic [31:0] mem3    [0:3*DEPTH-1];
  logic [31:0] exp_mem [0:3*DEPTH-1];

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  logic ev1, ev3;
  int   cyc;
  int   n_tests;
  int   n_fail;

  glb_access_arbiter #(.RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_bank_map(bank_map),
    .i_req_valid(req_valid), .o_req_ready(ready1), .i_req_addr(req_addr),
    .i_wr_data(wr_data), .o_glb_bank_sel(bank1), .o_glb_re(re1),
    .o_glb_we(we1), .o_glb_ra(ra1), .o_glb_wa(wa1), .o_glb_wd(wd1),
    .i_glb_rd(rd1_q), .o_rsp_valid(rsp_v1), .o_rsp_id(rsp_id1),
    .o_rsp_data(rsp_d1), .o_idle(idle1)
  );

  glb_access_arbiter #(.RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_bank_map(bank_map),
    .i_req_valid(req_valid), .o_req_ready(ready3), .i_req_addr(req_addr),
    .i_wr_data(wr_data), .o_glb_bank_sel(bank3), .o_glb_re(re3),
    .o_glb_we(we3), .o_glb_ra(ra3), .o_glb_wa(wa3), .o_glb_wd(wd3),
    .i_glb_rd(rd3_s2), .o_rsp_valid(rsp_v3), .o_rsp_id(rsp_id3),
    .o_rsp_data(rsp_d3), .o_idle(idle3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int bank, input int addr);
    return 32'hA000_0000 | (32'(bank) << 16) | 32'(addr);
  endfunction

  initial begin
    for (int b = 0; b < 3; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem1[b*DEPTH + a]    = pat(b, a);
        mem3[b*DEPTH + a]    = pat(b, a);
        exp_mem[b*DEPTH + a] = pat(b, a);
      end
    end
  end

  // GLB model, latency 1: write-before-read across cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
    end else begin
      if (we1) mem1[int'(bank1)*DEPTH + int'(wa1)] <= wd1;
      rd1_q <= re1 ? mem1[int'(bank1)*DEPTH + int'(ra1)] : 32'h0;
    end
  end

  // GLB model, latency 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd3_s0 <= '0;
      rd3_s1 <= '0;
      rd3_s2 <= '0;
    end else begin
      if (we3) mem3[int'(bank3)*DEPTH + int'(wa3)] <= wd3;
      rd3_s0 <= re3 ? mem3[int'(bank3)*DEPTH + int'(ra3)] : 32'h0;
      rd3_s1 <= rd3_s0;
      rd3_s2 <= rd3_s1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] bank_of(input int id);
    case (id)
      0:       return bank_map[5:4];
      1:       return bank_map[1:0];
      default: return bank_map[3:2];
    endcase
  endfunction

  // Response scoreboards: every cycle the valid flag must match the queue head's due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      ev1 = (q1.size() > 0) && (q1[0].due == cyc);
      check_eq("rsp_valid_lat1", {63'd0, rsp_v1}, {63'd0, ev1});
      if (ev1) begin
        e1 = q1.pop_front();
        if (rsp_v1) begin
          check_eq("rsp_id_lat1", {62'd0, rsp_id1}, {62'd0, e1.id});
          check_eq("rsp_data_lat1", {32'd0, rsp_d1}, {32'd0, e1.data});
        end
      end
      ev3 = (q3.size() > 0) && (q3[0].due == cyc);
      check_eq("rsp_valid_lat3", {63'd0, rsp_v3}, {63'd0, ev3});
      if (ev3) begin
        e3 = q3.pop_front();
        if (rsp_v3) begin
          check_eq("rsp_id_lat3", {62'd0, rsp_id3}, {62'd0, e3.id});
          check_eq("rsp_data_lat3", {32'd0, rsp_d3}, {32'd0, e3.data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, check grant and GLB port, queue expected reads.
  task automatic cycle_req(input logic [3:0] vld, input logic [3:0] exp_gnt);
    int            id;
    logic          exp_re, exp_we;
    logic [BW-1:0] exp_bk;
    logic [AW-1:0] exp_ra, exp_wa, a;
    logic [DW-1:0] exp_wd;
    exp_t          e;
    req_valid = vld;
    @(negedge clk);
    id = -1;
    for (int k = 0; k < 4; k++) if (exp_gnt[k]) id = k;
    exp_re = |exp_gnt[2:0];
    exp_we = exp_gnt[3];
    exp_bk = (id >= 0) ? bank_of(id) : '0;
    a      = (id >= 0) ? req_addr[id*AW +: AW] : '0;
    exp_ra = exp_re ? a : '0;
    exp_wa = exp_we ? a : '0;
    exp_wd = exp_we ? wr_data : '0;
    check_eq("ready_lat1", {60'd0, ready1}, {60'd0, exp_gnt});
    check_eq("ready_lat3", {60'd0, ready3}, {60'd0, exp_gnt});
    check_eq("glb_port_lat1", {2'd0, re1, we1, bank1, ra1, wa1, wd1},
             {2'd0, exp_re, exp_we, exp_bk, exp_ra, exp_wa, exp_wd});
    check_eq("glb_port_lat3", {2'd0, re3, we3, bank3, ra3, wa3, wd3},
             {2'd0, exp_re, exp_we, exp_bk, exp_ra, exp_wa, exp_wd});
    if (exp_we) exp_mem[int'(exp_bk)*DEPTH + int'(a)] = wr_data;
    if (exp_re) begin
      e.id   = 2'(id);
      e.data = exp_mem[int'(exp_bk)*DEPTH + int'(a)];
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc + 3;
      q3.push_back(e);
    end
    step();
  endtask

  task automatic set_addr(input int k, input int val);
    req_addr[k*AW +: AW] = AW'(val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    bank_map  = {2'd0, 2'd1, 2'd2};
    req_valid = 4'b0;
    req_addr  = '0;
    wr_data   = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctl_lat1", {52'd0, ready1, re1, we1, bank1, rsp_v1, rsp_id1, idle1}, 64'h001);
    check_eq("rst_ctl_lat3", {52'd0, ready3, re3, we3, bank3, rsp_v3, rsp_id3, idle3}, 64'h001);
    check_eq("rst_addr", {38'd0, ra1, wa1}, 64'd0);
    check_eq("rst_wdata", {32'd0, wd1}, 64'd0);
    check_eq("rst_rdata", {rsp_d1, rsp_d3}, 64'd0);
    step();
    rst_n = 1'b1;

    // Disabled: requests must be ignored.
    req_valid = 4'hF;
    repeat (10) begin
      @(negedge clk);
      check_eq("disabled_ready", {56'd0, ready1, ready3}, 64'd0);
      check_eq("disabled_strobes", {60'd0, re1, we1, re3, we3}, 64'd0);
      check_eq("disabled_idle", {62'd0, idle1, idle3}, 64'd3);
      step();
    end
    req_valid = 4'b0;
    en = 1'b1;
    step();

    // Single ifmap read at address 5.
    set_addr(0, 5);
    cycle_req(4'b0001, 4'b0001);
    check_eq("run_not_idle", {62'd0, idle1, idle3}, 64'd0);
    cycle_req(4'b0000, 4'b0000);

    // psum write then read-back of the same address.
    set_addr(3, 100);
    wr_data = 32'hDEAD_BEEF;
    cycle_req(4'b1000, 4'b1000);
    set_addr(2, 100);
    cycle_req(4'b0100, 4'b0100);
    set_addr(3, 200);
    wr_data = 32'hCAFE_0001;
    cycle_req(4'b1000, 4'b1000);

    // All four requesters held for eight cycles from pointer 0.
    set_addr(0, 8);
    set_addr(1, 42);
    set_addr(2, 77);
    set_addr(3, 300);
    wr_data = 32'h0BAD_F00D;
    for (int k = 0; k < 8; k++) cycle_req(4'hF, 4'(1 << (k % 4)));

    // Sparse request patterns: pointer skips idle requesters.
    cycle_req(4'b1100, 4'b0100);
    cycle_req(4'b1000, 4'b1000);
    cycle_req(4'b0011, 4'b0001);
    cycle_req(4'b0010, 4'b0010);
    cycle_req(4'b1001, 4'b1000);
    cycle_req(4'b0001, 4'b0001);
    cycle_req(4'b0000, 4'b0000);
    cycle_req(4'b0000, 4'b0000);

    // Drain with a latency-3 read in flight.
    set_addr(1, 33);
    cycle_req(4'b0010, 4'b0010);
    en = 1'b0;
    req_valid = 4'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("drain_ready", {56'd0, ready1, ready3}, 64'd0);
      check_eq("drain_idle_lat3", {63'd0, idle3}, {63'd0, (k == 4)});
      check_eq("drain_idle_lat1", {63'd0, idle1}, {63'd0, (k >= 3)});
      step();
    end

    // New bank map while idle.
    bank_map = {2'd2, 2'd0, 2'd1};
    step();
    en = 1'b1;
    step();
    set_addr(0, 9);
    set_addr(1, 10);
    set_addr(2, 11);
    set_addr(3, 12);
    wr_data = 32'h1234_5678;
    cycle_req(4'b0001, 4'b0001);
    cycle_req(4'b0010, 4'b0010);
    cycle_req(4'b0100, 4'b0100);
    cycle_req(4'b1000, 4'b1000);
    set_addr(2, 12);
    cycle_req(4'b0100, 4'b0100);
    cycle_req(4'b0000, 4'b0000);
    cycle_req(4'b0000, 4'b0000);
    cycle_req(4'b0000, 4'b0000);

    // Asynchronous reset with two latency-3 reads in flight.
    cycle_req(4'b0001, 4'b0001);
    cycle_req(4'b0010, 4'b0010);
    req_valid = 4'b0;
    step();
    check_eq("pre_reset_rsp_lat3", {63'd0, rsp_v3}, 64'd1);
    #1;
    rst_n = 1'b0;
    q1.delete();
    q3.delete();
    #1;
    check_eq("reset_rsp_drop", {62'd0, rsp_v1, rsp_v3}, 64'd0);
    check_eq("reset_idle", {62'd0, idle1, idle3}, 64'd3);
    step();
    rst_n = 1'b1;
    step();
    cycle_req(4'hF, 4'b0001);
    cycle_req(4'hF, 4'b0010);
    cycle_req(4'b0000, 4'b0000);
    cycle_req(4'b0000, 4'b0000);
    cycle_req(4'b0000, 4'b0000);
    cycle_req(4'b0000, 4'b0000);
    en = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check_eq("final_idle", {62'd0, idle1, idle3}, 64'd3);
    check_eq("queues_drained", 64'(q1.size() + q3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
